// File: rtl/pipe_stage_skid_reg.sv
// Generic inter-stage pipeline register: two-entry skid buffer under valid/ready,
// flush zeroes control only, saturating stall/flush performance counters.
module pipe_stage_skid_reg #(
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic              main_valid_q, main_valid_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              in_ready_q, in_ready_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic accept, drain, stall_inc, flush_inc;

    assign accept    = in_valid & in_ready_q;
    assign drain     = main_valid_q & out_ready;
    assign stall_inc = ~flush & main_valid_q & ~out_ready;
    assign flush_inc = flush & (main_valid_q | skid_valid_q);

    always_comb begin
        main_valid_d = main_valid_q;
        main_ctrl_d  = main_ctrl_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            main_ctrl_d  = '0;
            skid_ctrl_d  = '0;
        end else if (!main_valid_q) begin
            if (accept) begin
                main_valid_d = 1'b1;
                main_ctrl_d  = in_ctrl;
                main_data_d  = in_data;
            end
        end else if (drain) begin
            if (skid_valid_q) begin
                // in_ready is low whenever skid is full, so no accept can collide here
                main_ctrl_d  = skid_ctrl_q;
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_ctrl_d = in_ctrl;
                main_data_d = in_data;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (!skid_valid_q && accept) begin
            skid_valid_d = 1'b1;
            skid_ctrl_d  = in_ctrl;
            skid_data_d  = in_data;
        end

        in_ready_d = ~skid_valid_d;

        stall_cnt_d = stall_cnt_q;
        if (stall_inc && stall_cnt_q != CntMax) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        flush_cnt_d = flush_cnt_q;
        if (flush_inc && flush_cnt_q != CntMax) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_ctrl_q  <= '0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b1;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_ctrl_q  <= main_ctrl_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    // Control of a non-valid slot reads zero so downstream sees no side effects
    assign out_valid   = main_valid_q;
    assign out_ctrl    = main_valid_q ? main_ctrl_q : '0;
    assign out_data    = main_data_q;
    assign in_ready    = in_ready_q;
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Self-checking bench for pipe_stage_skid_reg: directed scenarios plus random traffic
// checked against a queue-based model of the stage contents.
module tb_pipe_stage_skid_reg;

    localparam int CW = 16;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          in_ready, out_valid;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [15:0]   stall_count, flush_count;

    logic          in_ready4, out_valid4;
    logic [CW-1:0] out_ctrl4;
    logic [DW-1:0] out_data4;
    logic [3:0]    stall_count4, flush_count4;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          m_q[$];
    logic [DW-1:0] m_last;
    int            m_stall, m_flush;

    always #5 clk = ~clk;

    pipe_stage_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_data(out_data), .stall_count(stall_count),
        .flush_count(flush_count)
    );

    pipe_stage_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid4), .out_ready(out_ready),
        .out_ctrl(out_ctrl4), .out_data(out_data4), .stall_count(stall_count4),
        .flush_count(flush_count4)
    );

    // Advance one clock, updating the FIFO-content model from the inputs seen at the edge
    task automatic tick();
        ent_t e;
        bit   acc;
        if (rst) begin
            m_q.delete();
            m_stall = 0;
            m_flush = 0;
            m_last  = '0;
        end else if (flush) begin
            if (m_q.size() > 0) m_flush++;
            m_q.delete();
        end else begin
            acc = in_valid && (m_q.size() < 2);
            if (m_q.size() > 0 && !out_ready) m_stall++;
            if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
            if (acc) begin
                e.c = in_ctrl;
                e.d = in_data;
                m_q.push_back(e);
            end
        end
        if (m_q.size() > 0) m_last = m_q[0].d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1; in_valid = 1'b1; in_ctrl = 16'hFFFF; in_data = {4{32'hDEADBEEF}};
        tick();
        rst = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b ctrl=%h data=%h rdy=%b required 0/0/0/1",
                     out_valid, out_ctrl, out_data, in_ready);
        end
        checks++;
        if (stall_count !== 16'd0 || flush_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_counters: stall=%0d flush=%0d required 0/0",
                     stall_count, flush_count);
        end
    endtask

    task automatic test_stream();
        logic [CW-1:0] ec;
        logic [DW-1:0] ed;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_ctrl  = CW'(i + 1);
            in_data  = DW'(32'h100 + i);
            ec = CW'(i + 1);
            ed = DW'(32'h100 + i);
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_ctrl !== ec || out_data !== ed || in_ready !== 1'b1)
            begin
                errors++;
                $display("FAIL stream_%0d: valid=%b ctrl=%h data=%h rdy=%b required 1/%h/%h/1",
                         i, out_valid, out_ctrl, out_data, in_ready, ec, ed);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || stall_count !== 16'd0) begin
            errors++;
            $display("FAIL stream_end: valid=%b stall=%0d required 0/0", out_valid, stall_count);
        end
    endtask

    task automatic test_back_pressure();
        logic [CW-1:0] exp_c[5] = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd0};
        logic          exp_r[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic          exp_v[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int            idx;
        out_ready = 1'b0;
        in_valid  = 1'b1; in_ctrl = 16'd1; in_data = DW'(32'h201);
        tick();
        checks++;
        if (out_ctrl !== exp_c[0] || in_ready !== exp_r[0]) begin
            errors++;
            $display("FAIL bp_first: ctrl=%h rdy=%b required %h/%b",
                     out_ctrl, in_ready, exp_c[0], exp_r[0]);
        end
        in_ctrl = 16'd2; in_data = DW'(32'h202);
        tick();
        in_ctrl = 16'd3; in_data = DW'(32'h203);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (out_ctrl !== exp_c[1] || in_ready !== exp_r[1] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold_%0d: ctrl=%h rdy=%b valid=%b required %h/%b/1",
                         k, out_ctrl, in_ready, out_valid, exp_c[1], exp_r[1]);
            end
            if (k == 0) tick();
        end
        out_ready = 1'b1;
        for (idx = 2; idx < 5; idx++) begin
            tick();
            if (idx == 3) in_valid = 1'b0;
            checks++;
            if (out_valid !== exp_v[idx] || out_ctrl !== exp_c[idx] || in_ready !== exp_r[idx])
            begin
                errors++;
                $display("FAIL bp_drain_%0d: valid=%b ctrl=%h rdy=%b required %b/%h/%b",
                         idx, out_valid, out_ctrl, in_ready, exp_v[idx], exp_c[idx], exp_r[idx]);
            end
        end
        checks++;
        if (stall_count !== 16'd2) begin
            errors++;
            $display("FAIL bp_stall_count: got %0d required 2", stall_count);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 16'hA; in_data = DW'(32'h3A);
        tick();
        in_ctrl = 16'hB; in_data = DW'(32'h3B);
        tick();
        flush = 1'b1; in_ctrl = 16'hC; in_data = DW'(32'h3C);
        tick();
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== DW'(32'h3A) ||
            in_ready !== 1'b1 || flush_count !== 16'd1) begin
            errors++;
            $display("FAIL flush_full: valid=%b ctrl=%h data=%h rdy=%b fc=%0d required 0/0/3a/1/1",
                     out_valid, out_ctrl, out_data, in_ready, flush_count);
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || stall_count !== 16'd3) begin
            errors++;
            $display("FAIL flush_dropped: valid=%b stall=%0d required 0/3", out_valid, stall_count);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (flush_count !== 16'd1 || flush_count4 !== 4'd1) begin
            errors++;
            $display("FAIL flush_empty: fc=%0d fc4=%0d required 1/1", flush_count, flush_count4);
        end
    endtask

    task automatic test_rst_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 16'h11; in_data = DW'(32'h411);
        tick();
        in_ctrl = 16'h12; in_data = DW'(32'h412);
        tick();
        rst = 1'b1; flush = 1'b1;
        tick();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0 || in_ready !== 1'b1 ||
            flush_count !== 16'd0 || stall_count !== 16'd0) begin
            errors++;
            $display("FAIL rst_flush: valid=%b ctrl=%h data=%h rdy=%b fc=%0d sc=%0d req 0/0/0/1/0/0",
                     out_valid, out_ctrl, out_data, in_ready, flush_count, stall_count);
        end
    endtask

    task automatic test_saturate();
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 16'h5; in_data = DW'(32'h55);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (stall_count4 !== 4'd15 || stall_count !== 16'd20 || out_valid4 !== 1'b1) begin
            errors++;
            $display("FAIL stall_saturate: sc4=%0d sc16=%0d v4=%b required 15/20/1",
                     stall_count4, stall_count, out_valid4);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [CW-1:0] ec;
        logic [DW-1:0] ed;
        logic [15:0]   es, ef;
        logic [3:0]    es4, ef4;
        int            bad = 0;
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 149) == 0);
            flush     = ($urandom_range(0, 29) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_ctrl   = CW'($urandom);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            tick();
            ec  = (m_q.size() > 0) ? m_q[0].c : '0;
            ed  = m_last;
            es  = (m_stall > 65535) ? 16'hFFFF : 16'(m_stall);
            ef  = (m_flush > 65535) ? 16'hFFFF : 16'(m_flush);
            es4 = (m_stall > 15) ? 4'hF : 4'(m_stall);
            ef4 = (m_flush > 15) ? 4'hF : 4'(m_flush);
            checks++;
            if (out_valid !== (m_q.size() > 0) || out_ctrl !== ec || out_data !== ed ||
                in_ready !== (m_q.size() < 2)) begin
                errors++;
                bad++;
                if (bad < 10)
                    $display("FAIL rand_out_%0d: v=%b c=%h d=%h r=%b required %b/%h/%h/%b", i,
                             out_valid, out_ctrl, out_data, in_ready, m_q.size() > 0, ec, ed,
                             m_q.size() < 2);
            end
            checks++;
            if (stall_count !== es || flush_count !== ef || stall_count4 !== es4 ||
                flush_count4 !== ef4) begin
                errors++;
                bad++;
                if (bad < 10)
                    $display("FAIL rand_cnt_%0d: sc=%0d fc=%0d sc4=%0d fc4=%0d required %0d/%0d/%0d/%0d",
                             i, stall_count, flush_count, stall_count4, flush_count4,
                             es, ef, es4, ef4);
            end
        end
    endtask

    initial begin
        idle_inputs();
        m_last = '0; m_stall = 0; m_flush = 0;
        rst = 1'b1;
        tick();
        tick();
        test_reset();
        test_stream();
        test_back_pressure();
        test_flush();
        test_rst_flush();
        test_saturate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
- Parametrised, generic successor to the fixed-field inter-stage pipeline registers (ID->EXE, EXE->MEM, MEM->WB).
- Carries a control bundle and a data bundle between stages under a valid/ready handshake, using a two-entry skid buffer so that backpressure is registered.
- Supports flush (bubble insertion) that zeroes control only, plus saturating stall/flush performance counters.
- Instantiated between every pair of pipeline stages, replacing the per-stage hand-written registers.

Parameters:
- CTRL_W, 16, width of the control bundle (write-back enable, mem read/write, exec command, S, branch, ...). Zeroed on flush.
- DATA_W, 128, width of the data bundle (PC, operand values, immediates, register indices). Not cleared on flush.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- flush  input  1  discard all held and incoming entries this cycle
- in_valid  input  1  upstream entry present
- in_ready  output  1  stage can accept; registered
- in_ctrl  input  CTRL_W  upstream control bundle
- in_data  input  DATA_W  upstream data bundle
- out_valid  output  1  entry presented downstream
- out_ready  input  1  downstream accepts
- out_ctrl  output  CTRL_W  control of presented entry
- out_data  output  DATA_W  data of presented entry
- stall_count  output  CNT_W  cycles with out_valid=1 and out_ready=0
- flush_count  output  CNT_W  number of flush cycles that discarded at least one valid entry

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Storage is two entries, main and skid, each holding {valid, ctrl, data}.
  - out_* always reflect main.
  - in_ready = !skid.valid, driven from a flop.
- Reset (priority 1): main.valid=0, skid.valid=0, all ctrl=0, all data=0, in_ready=1, stall_count=0, flush_count=0. An input presented in the reset cycle is dropped.
- Flush (priority 2, rst=0):
  - Next state: main.valid=0, skid.valid=0, main.ctrl=0, skid.ctrl=0, in_ready=1.
  - Data fields hold their values.
  - An input presented in the same cycle is dropped, even if in_ready=1.
  - flush_count increments if main.valid or skid.valid was 1.
- Normal operation (rst=0, flush=0). Accept = in_valid & in_ready; drain = out_valid & out_ready.
  - Main empty: on accept, main <= input.
  - Main full, drain, skid empty: on accept, main <= input; otherwise main.valid <= 0.
  - Main full, drain, skid full: main <= skid, skid.valid <= 0. No accept is possible because in_ready=0.
  - Main full, no drain, skid empty, accept: skid <= input. in_ready goes to 0 next cycle.
  - Main full, no drain, skid full: hold everything.
- Order and integrity: strict FIFO order, no duplication, no loss except on rst or flush.
- Latency: 1 cycle from accept to out_valid when the stage is empty. Throughput is 1 entry per cycle with out_ready held at 1.
- in_ready only falls the cycle after skid is filled. This registered backpressure is the reason for the skid entry.
- Invalid entries: while out_valid=0, out_ctrl must read 0. Downstream may rely on ctrl=0 meaning no side effects.
- Counters:
  - Saturate at 2^CNT_W-1 with no wrap.
  - stall_count increments in any non-reset, non-flush cycle with out_valid=1 and out_ready=0.
  - Both counters clear only on rst.
- Simultaneous events:
  - rst and flush together: reset behaviour.
  - flush and drain together: the flush still counts; the drain is irrelevant.
- Input stability: in_ctrl/in_data may change while in_valid=0. The block must not require them stable.

Test Plan:
- Reset with in_valid=1, in_ctrl=16'hFFFF: the next cycle shows out_valid=0, out_ctrl=0, out_data=0, in_ready=1, both counters 0.
- Stream entries with ctrl=1..8 and data=0x100..0x107, out_ready=1 constant: outputs appear in order with 1-cycle latency, in_ready stays 1, stall_count=0.
- Stream 3 entries with out_ready=0:
  - Main holds entry 1; skid holds entry 2; in_ready falls the cycle after the skid fills; entry 3 waits upstream.
  - Raise out_ready: outputs are 1, 2, 3 in order.
  - stall_count equals the number of out_ready=0 cycles during which out_valid=1.
- Fill main and skid (ctrl=0xA, 0xB), then pulse flush with in_valid=1: next cycle out_valid=0, out_ctrl=0, data unchanged, in_ready=1, input dropped, flush_count=1. A flush on an empty stage leaves flush_count unchanged.
- Assert flush and rst together with a full stage: reset values result and flush_count=0.
- With CNT_W=4, hold out_ready=0 for 20 cycles with out_valid=1: stall_count saturates at 15.
